// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if
//   Groups the request/done/grant signals shared between the CPU/DMA side and
//   the bus arbiter.
//   master modport : drives cpu_req, cpu_done, dma_req, dma_done;
//                    observes cpu_gnt, dma_gnt, ade, bus_busy, dma_preempt, hold_cnt
//   slave modport  : the arbiter's view (inputs and outputs reversed)
interface bus_arbiter_if #(
    parameter int CNT_W = 3
);
    logic             cpu_req;
    logic             cpu_done;
    logic             dma_req;
    logic             dma_done;
    logic             cpu_gnt;
    logic             dma_gnt;
    logic             ade;
    logic             bus_busy;
    logic             dma_preempt;
    logic [CNT_W-1:0] hold_cnt;

    modport master (
        output cpu_req, cpu_done, dma_req, dma_done,
        input  cpu_gnt, dma_gnt, ade, bus_busy, dma_preempt, hold_cnt
    );

    modport slave (
        input  cpu_req, cpu_done, dma_req, dma_done,
        output cpu_gnt, dma_gnt, ade, bus_busy, dma_preempt, hold_cnt
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Owns the shared address/data bus between the CPU and the DMA engine. Grants
//   one master at a time, drives ade (DMA is bus owner), inserts a one-cycle
//   turnaround between owners and bounds DMA tenure while the CPU is waiting.
//   Ports:
//     i_clk    in   system clock, all logic on posedge
//     i_rst_n  in   synchronous reset, active low
//     io_arb   slave modport of bus_arbiter_if:
//                in  cpu_req, cpu_done, dma_req, dma_done
//                out cpu_gnt, dma_gnt, ade, bus_busy, dma_preempt, hold_cnt
//   All outputs are registered.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | bus free, arbitrate requests
//   S_CPU   | CPU owns the bus, never preempted
//   S_DMA   | DMA owns the bus, hold_cnt tracks tenure length
//   S_TURN  | one dead cycle between owners, arbitrate like S_IDLE
module bus_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    bus_arbiter_if.slave  io_arb
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_DMA  = 2'd2,
        S_TURN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] L_HOLD_MAX  = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] L_HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           r_state;
    logic             r_last_dma;     // 1: DMA was the most recent owner
    logic             r_cpu_gnt;
    logic             r_dma_gnt;
    logic             r_bus_busy;
    logic             r_dma_preempt;
    logic [CNT_W-1:0] r_hold_cnt;

    state_t           w_state_nxt;
    logic             w_last_dma_nxt;
    logic             w_preempt_nxt;
    logic             w_cpu_gnt_nxt;
    logic             w_dma_gnt_nxt;
    logic             w_bus_busy_nxt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_last_dma    <= 1'b0;
            r_cpu_gnt     <= 1'b0;
            r_dma_gnt     <= 1'b0;
            r_bus_busy    <= 1'b0;
            r_dma_preempt <= 1'b0;
            r_hold_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_dma    <= w_last_dma_nxt;
            r_cpu_gnt     <= w_cpu_gnt_nxt;
            r_dma_gnt     <= w_dma_gnt_nxt;
            r_bus_busy    <= w_bus_busy_nxt;
            r_dma_preempt <= w_preempt_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt    = r_state;
        w_last_dma_nxt = r_last_dma;
        w_preempt_nxt  = 1'b0;
        case (r_state)
            S_IDLE, S_TURN: begin
                if (io_arb.cpu_req && io_arb.dma_req) begin
                    // Tie goes to whoever did not own the bus last
                    w_state_nxt = r_last_dma ? S_CPU : S_DMA;
                end else if (io_arb.cpu_req) begin
                    w_state_nxt = S_CPU;
                end else if (io_arb.dma_req) begin
                    w_state_nxt = S_DMA;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CPU: begin
                if (io_arb.cpu_done || !io_arb.cpu_req) begin
                    w_state_nxt    = S_TURN;
                    w_last_dma_nxt = 1'b0;
                end
            end
            S_DMA: begin
                // A normal release wins over preemption, so no pulse then.
                // >= so a CPU request arriving after the counter saturated
                // still ends the tenure on the next edge.
                if (io_arb.dma_done || !io_arb.dma_req) begin
                    w_state_nxt    = S_TURN;
                    w_last_dma_nxt = 1'b1;
                end else if (io_arb.cpu_req && (r_hold_cnt >= L_HOLD_LAST)) begin
                    w_state_nxt    = S_TURN;
                    w_last_dma_nxt = 1'b1;
                    w_preempt_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic, computed from the next state so outputs can be registered
    always_comb begin
        w_cpu_gnt_nxt  = (w_state_nxt == S_CPU);
        w_dma_gnt_nxt  = (w_state_nxt == S_DMA);
        w_bus_busy_nxt = (w_state_nxt != S_IDLE);
        w_hold_cnt_nxt = '0;
        if ((w_state_nxt == S_DMA) && (r_state == S_DMA)) begin
            w_hold_cnt_nxt = (r_hold_cnt == L_HOLD_MAX) ? r_hold_cnt
                                                        : r_hold_cnt + CNT_W'(1);
        end
    end

    assign io_arb.cpu_gnt     = r_cpu_gnt;
    assign io_arb.dma_gnt     = r_dma_gnt;
    assign io_arb.ade         = r_dma_gnt;
    assign io_arb.bus_busy    = r_bus_busy;
    assign io_arb.dma_preempt = r_dma_preempt;
    assign io_arb.hold_cnt    = r_hold_cnt;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Directed table-driven checks of bus_arbiter plus a randomized run that
//   watches the grant-exclusion and turnaround invariants.
//   Stimulus row : {rst_n, cpu_req, cpu_done, dma_req, dma_done}, applied before an edge
//   Expect row   : {cpu_gnt, dma_gnt, ade, bus_busy, dma_preempt, hold_cnt[2:0]}
//                  observed 1 time unit after that edge
module tb_bus_arbiter;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    bus_arbiter_if #(.CNT_W(3)) arb ();

    bus_arbiter #(
        .HOLD_MAX (4),
        .CNT_W    (3)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_arb  (arb)
    );

    wire [7:0] w_obs = {arb.cpu_gnt, arb.dma_gnt, arb.ade, arb.bus_busy,
                        arb.dma_preempt, arb.hold_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        logic [4:0] stim [5];
        logic [7:0] expv [5];
        stim = '{5'b0_1010, 5'b0_1010, 5'b1_1010, 5'b1_0000, 5'b1_0000};
        expv = '{8'b0000_0000, 8'b0000_0000, 8'b0111_0000, 8'b0001_0000, 8'b0000_0000};
        for (int i = 0; i < 5; i++) begin
            {rst_n, arb.cpu_req, arb.cpu_done, arb.dma_req, arb.dma_done} = stim[i];
            @(posedge clk); #1;
            n_vec++;
            if (w_obs !== expv[i]) begin
                n_err++;
                $display("FAIL reset[%0d]: got %b expected %b", i, w_obs, expv[i]);
            end
        end
    endtask

    task automatic test_cpu_alone;
        logic [4:0] stim [7];
        logic [7:0] expv [7];
        stim = '{5'b0_0000, 5'b1_1000, 5'b1_1001, 5'b1_1000, 5'b1_1100,
                 5'b1_0000, 5'b1_0000};
        expv = '{8'b0000_0000, 8'b1001_0000, 8'b1001_0000, 8'b1001_0000, 8'b0001_0000,
                 8'b0000_0000, 8'b0000_0000};
        for (int i = 0; i < 7; i++) begin
            {rst_n, arb.cpu_req, arb.cpu_done, arb.dma_req, arb.dma_done} = stim[i];
            @(posedge clk); #1;
            n_vec++;
            if (w_obs !== expv[i]) begin
                n_err++;
                $display("FAIL cpu_alone[%0d]: got %b expected %b", i, w_obs, expv[i]);
            end
        end
    endtask

    task automatic test_round_robin;
        logic [4:0] stim [11];
        logic [7:0] expv [11];
        stim = '{5'b0_0000, 5'b1_1010, 5'b1_1011, 5'b1_1010, 5'b1_1110, 5'b1_1010,
                 5'b1_1010, 5'b1_1011, 5'b1_1010, 5'b1_0000, 5'b1_0000};
        expv = '{8'b0000_0000, 8'b0111_0000, 8'b0001_0000, 8'b1001_0000, 8'b0001_0000,
                 8'b0111_0000, 8'b0111_0001, 8'b0001_0000, 8'b1001_0000, 8'b0001_0000,
                 8'b0000_0000};
        for (int i = 0; i < 11; i++) begin
            {rst_n, arb.cpu_req, arb.cpu_done, arb.dma_req, arb.dma_done} = stim[i];
            @(posedge clk); #1;
            n_vec++;
            if (w_obs !== expv[i]) begin
                n_err++;
                $display("FAIL round_robin[%0d]: got %b expected %b", i, w_obs, expv[i]);
            end
        end
    endtask

    task automatic test_preempt;
        logic [4:0] stim [11];
        logic [7:0] expv [11];
        stim = '{5'b0_0000, 5'b1_0010, 5'b1_1010, 5'b1_1010, 5'b1_1010, 5'b1_1010,
                 5'b1_1010, 5'b1_1110, 5'b1_0010, 5'b1_0000, 5'b1_0000};
        expv = '{8'b0000_0000, 8'b0111_0000, 8'b0111_0001, 8'b0111_0010, 8'b0111_0011,
                 8'b0001_1000, 8'b1001_0000, 8'b0001_0000, 8'b0111_0000, 8'b0001_0000,
                 8'b0000_0000};
        for (int i = 0; i < 11; i++) begin
            {rst_n, arb.cpu_req, arb.cpu_done, arb.dma_req, arb.dma_done} = stim[i];
            @(posedge clk); #1;
            n_vec++;
            if (w_obs !== expv[i]) begin
                n_err++;
                $display("FAIL preempt[%0d]: got %b expected %b", i, w_obs, expv[i]);
            end
        end
    endtask

    // Release and preemption condition in the same cycle: plain release, no pulse
    task automatic test_done_vs_preempt;
        logic [4:0] stim [9];
        logic [7:0] expv [9];
        stim = '{5'b0_0000, 5'b1_1010, 5'b1_1110, 5'b1_1010, 5'b1_1010, 5'b1_1011,
                 5'b1_1010, 5'b1_0000, 5'b1_0000};
        expv = '{8'b0000_0000, 8'b0111_0000, 8'b0111_0001, 8'b0111_0010, 8'b0111_0011,
                 8'b0001_0000, 8'b1001_0000, 8'b0001_0000, 8'b0000_0000};
        for (int i = 0; i < 9; i++) begin
            {rst_n, arb.cpu_req, arb.cpu_done, arb.dma_req, arb.dma_done} = stim[i];
            @(posedge clk); #1;
            n_vec++;
            if (w_obs !== expv[i]) begin
                n_err++;
                $display("FAIL done_vs_preempt[%0d]: got %b expected %b", i, w_obs, expv[i]);
            end
        end
    endtask

    task automatic test_reset_mid_dma;
        logic [4:0] stim [8];
        logic [7:0] expv [8];
        stim = '{5'b0_0000, 5'b1_0010, 5'b1_0010, 5'b1_0010, 5'b0_0010, 5'b1_0010,
                 5'b1_0000, 5'b1_0000};
        expv = '{8'b0000_0000, 8'b0111_0000, 8'b0111_0001, 8'b0111_0010, 8'b0000_0000,
                 8'b0111_0000, 8'b0001_0000, 8'b0000_0000};
        for (int i = 0; i < 8; i++) begin
            {rst_n, arb.cpu_req, arb.cpu_done, arb.dma_req, arb.dma_done} = stim[i];
            @(posedge clk); #1;
            n_vec++;
            if (w_obs !== expv[i]) begin
                n_err++;
                $display("FAIL reset_mid_dma[%0d]: got %b expected %b", i, w_obs, expv[i]);
            end
        end
    endtask

    task automatic test_random;
        logic prev_cpu;
        logic prev_dma;
        rst_n = 1'b0;
        {arb.cpu_req, arb.cpu_done, arb.dma_req, arb.dma_done} = 4'b0000;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        prev_cpu = 1'b0;
        prev_dma = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(3) == 0) arb.cpu_req = ~arb.cpu_req;
            if ($urandom_range(3) == 0) arb.dma_req = ~arb.dma_req;
            arb.cpu_done = ($urandom_range(5) == 0);
            arb.dma_done = ($urandom_range(5) == 0);
            @(posedge clk); #1;
            n_vec++;
            if ((arb.cpu_gnt & arb.dma_gnt) !== 1'b0) begin
                n_err++;
                $display("FAIL rand_overlap[%0d]: cpu_gnt=%b dma_gnt=%b, need not both 1",
                         i, arb.cpu_gnt, arb.dma_gnt);
            end
            n_vec++;
            if (((prev_cpu & arb.dma_gnt) | (prev_dma & arb.cpu_gnt)) !== 1'b0) begin
                n_err++;
                $display("FAIL rand_turnaround[%0d]: prev cpu/dma=%b%b now cpu/dma=%b%b, need dead cycle",
                         i, prev_cpu, prev_dma, arb.cpu_gnt, arb.dma_gnt);
            end
            prev_cpu = arb.cpu_gnt;
            prev_dma = arb.dma_gnt;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        {arb.cpu_req, arb.cpu_done, arb.dma_req, arb.dma_done} = 4'b0000;
        test_reset();
        test_cpu_alone();
        test_round_robin();
        test_preempt();
        test_done_vs_preempt();
        test_reset_mid_dma();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
